// File: rtl/if_pipe_stage_pkg.sv
// Shared widths, constants and types for the instruction-fetch stage.
package if_pipe_stage_pkg;

   localparam int unsigned PC_WIDTH    = 10;
   localparam int unsigned INSTR_WIDTH = 32;

   localparam logic [PC_WIDTH-1:0]    RESET_PC  = PC_WIDTH'(0);
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(0);
   localparam logic [PC_WIDTH-1:0]    PC_INC    = PC_WIDTH'(4);

   // Next-PC source select.
   typedef enum logic [1:0] {
      SEL_HOLD,
      SEL_SEQ,
      SEL_BRANCH,
      SEL_JUMP
   } next_sel_e;

   // IF/ID pipeline register payload.
   typedef struct packed {
      logic                   valid;
      logic [PC_WIDTH-1:0]    pc_plus4;
      logic [INSTR_WIDTH-1:0] instr;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc_plus4: PC_WIDTH'(0), instr: NOP_INSTR};

endpackage

// File: rtl/if_pipe_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
interface if_pipe_stage_if;
   import if_pipe_stage_pkg::*;

   logic [PC_WIDTH-1:0]    imem_addr;
   logic [INSTR_WIDTH-1:0] imem_rdata;
   logic                   imem_ready;

   modport master (output imem_addr, input imem_rdata, input imem_ready);
   modport slave  (input imem_addr, output imem_rdata, output imem_ready);

endinterface

// File: rtl/if_pipe_stage_if_id_reg.sv
// IF/ID pipeline register: holds when load=0, loads a bubble or fetched data otherwise.
module if_pipe_stage_if_id_reg
   import if_pipe_stage_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  logic   bubble,
   input  if_id_t d,
   output if_id_t q
);

   // Pipeline register with async clear to a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= IF_ID_BUBBLE;
      end else if (load) begin
         q <= bubble ? IF_ID_BUBBLE : d;
      end
   end

endmodule

// File: rtl/if_pipe_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC and feeds the IF/ID register.
module if_pipe_stage
   import if_pipe_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   if_pipe_stage_if.master        imem,
   input  logic                   Data_Hazard,
   input  logic                   IF_Flush,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_address,
   input  logic                   jump,
   input  logic [PC_WIDTH-1:0]    jump_address,
   output logic [PC_WIDTH-1:0]    pc,
   output logic [PC_WIDTH-1:0]    if_id_pc_plus4,
   output logic [INSTR_WIDTH-1:0] if_id_instr,
   output logic                   if_id_valid
);

   next_sel_e           sel;
   logic                load;
   logic                bubble;
   logic [PC_WIDTH-1:0] pc_plus4;
   logic [PC_WIDTH-1:0] pc_next;
   if_id_t              fetch_d;
   if_id_t              if_id_q;

   assign imem.imem_addr = pc;
   assign pc_plus4       = pc + PC_INC;

   // Priority decode: stall, redirect, flush, memory wait, normal fetch.
   always_comb begin
      sel    = SEL_SEQ;
      load   = 1'b1;
      bubble = 1'b0;
      if (!Data_Hazard) begin
         sel  = SEL_HOLD;
         load = 1'b0;
      end else if (jump) begin
         sel    = SEL_JUMP;
         bubble = 1'b1;
      end else if (branch_taken) begin
         sel    = SEL_BRANCH;
         bubble = 1'b1;
      end else if (IF_Flush) begin
         sel    = imem.imem_ready ? SEL_SEQ : SEL_HOLD;
         bubble = 1'b1;
      end else if (!imem.imem_ready) begin
         sel    = SEL_HOLD;
         bubble = 1'b1;
      end
   end

   // Next-PC mux.
   always_comb begin
      pc_next = pc;
      case (sel)
         SEL_HOLD:   pc_next = pc;
         SEL_SEQ:    pc_next = pc_plus4;
         SEL_BRANCH: pc_next = branch_address;
         SEL_JUMP:   pc_next = jump_address;
         default:    pc_next = pc;
      endcase
   end

   // PC register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

   assign fetch_d = '{valid: 1'b1, pc_plus4: pc_plus4, instr: imem.imem_rdata};

   if_pipe_stage_if_id_reg u_if_id_reg (
      .clk    (clk),
      .rst_n  (reset),
      .load   (load),
      .bubble (bubble),
      .d      (fetch_d),
      .q      (if_id_q)
   );

   assign if_id_pc_plus4 = if_id_q.pc_plus4;
   assign if_id_instr    = if_id_q.instr;
   assign if_id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_if_pipe_stage.sv
// Self-checking bench for the instruction-fetch stage.
module tb_if_pipe_stage;

   logic       clk;
   logic       reset;
   logic       dh, fl, br, jp, rdy_drv;
   logic [9:0] ba, ja;
   logic [9:0] pc, pp4;
   logic [31:0] instr;
   logic       valid;
   logic [31:0] mem_key;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   logic [9:0]  m_pc, m_pp4;
   logic [31:0] m_instr;
   logic        m_valid;

   typedef struct {
      logic        dh, fl, br;
      logic [9:0]  ba;
      logic        jp;
      logic [9:0]  ja;
      logic        rdy;
      logic [9:0]  e_pc, e_pp4;
      logic [31:0] e_instr;
      logic        e_valid;
   } vec_t;

   vec_t tbl[21];

   if_pipe_stage_if bus();

   // Instruction memory: word depends on address and a per-phase key.
   assign bus.imem_rdata = (32'h1000_0000 + {22'd0, bus.imem_addr}) ^ mem_key;
   assign bus.imem_ready = rdy_drv;

   if_pipe_stage dut (
      .clk            (clk),
      .reset          (reset),
      .imem           (bus),
      .Data_Hazard    (dh),
      .IF_Flush       (fl),
      .branch_taken   (br),
      .branch_address (ba),
      .jump           (jp),
      .jump_address   (ja),
      .pc             (pc),
      .if_id_pc_plus4 (pp4),
      .if_id_instr    (instr),
      .if_id_valid    (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc    = 10'd0;
      m_pp4   = 10'd0;
      m_instr = 32'd0;
      m_valid = 1'b0;
   endtask

   // Apply one cycle of inputs, advance the model, optionally compare to it.
   task automatic cycle(input logic i_dh, input logic i_fl, input logic i_br, input logic [9:0] i_ba,
                        input logic i_jp, input logic [9:0] i_ja, input logic i_rdy, input bit cmp_model);
      logic [31:0] word;
      logic [9:0]  seq;
      dh = i_dh; fl = i_fl; br = i_br; ba = i_ba; jp = i_jp; ja = i_ja; rdy_drv = i_rdy;
      #1;
      chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      word = (32'h1000_0000 + 32'(m_pc)) ^ mem_key;
      @(posedge clk);
      if (i_dh) begin
         seq = 10'((int'(m_pc) + 4) % 1024);
         if (i_rdy && !i_jp && !i_br && !i_fl) begin
            m_instr = word; m_pp4 = seq; m_valid = 1'b1;
         end else begin
            m_instr = 32'd0; m_pp4 = 10'd0; m_valid = 1'b0;
         end
         if (i_jp)       m_pc = i_ja;
         else if (i_br)  m_pc = i_ba;
         else if (i_rdy) m_pc = seq;
      end
      #1;
      if (cmp_model) begin
         chk("model pc", 32'(pc), 32'(m_pc));
         chk("model pc_plus4", 32'(pp4), 32'(m_pp4));
         chk("model instr", instr, m_instr);
         chk("model valid", 32'(valid), 32'(m_valid));
      end
   endtask

   // Assert reset between clock edges and check that outputs clear immediately.
   task automatic mid_reset(input string tag);
      #2;
      reset = 1'b0;
      #1;
      chk({tag, " pc"}, 32'(pc), 32'd0);
      chk({tag, " imem_addr"}, 32'(bus.imem_addr), 32'd0);
      chk({tag, " pc_plus4"}, 32'(pp4), 32'd0);
      chk({tag, " instr"}, instr, 32'd0);
      chk({tag, " valid"}, 32'(valid), 32'd0);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic chk_first_fetch(input string tag);
      chk({tag, " pc"}, 32'(pc), 32'd4);
      chk({tag, " pc_plus4"}, 32'(pp4), 32'd4);
      chk({tag, " instr"}, instr, 32'h1000_0000);
      chk({tag, " valid"}, 32'(valid), 32'd1);
   endtask

   initial begin
      // dh fl br ba jp ja rdy | pc pp4 instr valid
      tbl[0]  = '{1'b1,1'b0,1'b0,10'd0,  1'b0,10'd0,   1'b1, 10'd4,   10'd4,   32'h1000_0000, 1'b1};
      tbl[1]  = '{1'b1,1'b0,1'b0,10'd0,  1'b0,10'd0,   1'b1, 10'd8,   10'd8,   32'h1000_0004, 1'b1};
      tbl[2]  = '{1'b0,1'b0,1'b1,10'd100,1'b0,10'd0,   1'b1, 10'd8,   10'd8,   32'h1000_0004, 1'b1};
      tbl[3]  = '{1'b0,1'b0,1'b1,10'd100,1'b0,10'd0,   1'b1, 10'd8,   10'd8,   32'h1000_0004, 1'b1};
      tbl[4]  = '{1'b1,1'b0,1'b0,10'd0,  1'b0,10'd0,   1'b1, 10'd12,  10'd12,  32'h1000_0008, 1'b1};
      tbl[5]  = '{1'b1,1'b0,1'b1,10'd100,1'b0,10'd0,   1'b1, 10'd100, 10'd0,   32'h0,         1'b0};
      tbl[6]  = '{1'b1,1'b0,1'b0,10'd0,  1'b0,10'd0,   1'b1, 10'd104, 10'd104, 32'h1000_0064, 1'b1};
      tbl[7]  = '{1'b1,1'b0,1'b1,10'd100,1'b1,10'd200, 1'b1, 10'd200, 10'd0,   32'h0,         1'b0};
      tbl[8]  = '{1'b1,1'b0,1'b0,10'd0,  1'b0,10'd0,   1'b1, 10'd204, 10'd204, 32'h1000_00C8, 1'b1};
      tbl[9]  = '{1'b1,1'b0,1'b0,10'd0,  1'b1,10'd16,  1'b1, 10'd16,  10'd0,   32'h0,         1'b0};
      tbl[10] = '{1'b1,1'b0,1'b0,10'd0,  1'b0,10'd0,   1'b0, 10'd16,  10'd0,   32'h0,         1'b0};
      tbl[11] = '{1'b1,1'b0,1'b0,10'd0,  1'b0,10'd0,   1'b0, 10'd16,  10'd0,   32'h0,         1'b0};
      tbl[12] = '{1'b1,1'b0,1'b0,10'd0,  1'b0,10'd0,   1'b0, 10'd16,  10'd0,   32'h0,         1'b0};
      tbl[13] = '{1'b1,1'b0,1'b0,10'd0,  1'b0,10'd0,   1'b1, 10'd20,  10'd20,  32'h1000_0010, 1'b1};
      tbl[14] = '{1'b1,1'b1,1'b0,10'd0,  1'b0,10'd0,   1'b1, 10'd24,  10'd0,   32'h0,         1'b0};
      tbl[15] = '{1'b1,1'b1,1'b0,10'd0,  1'b0,10'd0,   1'b0, 10'd24,  10'd0,   32'h0,         1'b0};
      tbl[16] = '{1'b1,1'b1,1'b1,10'd40, 1'b0,10'd0,   1'b1, 10'd40,  10'd0,   32'h0,         1'b0};
      tbl[17] = '{1'b1,1'b0,1'b0,10'd0,  1'b1,10'd1020,1'b1, 10'd1020,10'd0,   32'h0,         1'b0};
      tbl[18] = '{1'b1,1'b0,1'b0,10'd0,  1'b0,10'd0,   1'b1, 10'd0,   10'd0,   32'h1000_03FC, 1'b1};
      tbl[19] = '{1'b1,1'b0,1'b0,10'd0,  1'b0,10'd0,   1'b1, 10'd4,   10'd4,   32'h1000_0000, 1'b1};
      tbl[20] = '{1'b0,1'b1,1'b0,10'd0,  1'b0,10'd0,   1'b0, 10'd4,   10'd4,   32'h1000_0000, 1'b1};

      reset = 1'b0; dh = 1'b1; fl = 1'b0; br = 1'b0; jp = 1'b0;
      ba = 10'd0; ja = 10'd0; rdy_drv = 1'b1; mem_key = 32'd0;
      model_reset();

      @(posedge clk);
      #1;
      chk("reset pc", 32'(pc), 32'd0);
      chk("reset imem_addr", 32'(bus.imem_addr), 32'd0);
      chk("reset pc_plus4", 32'(pp4), 32'd0);
      chk("reset instr", instr, 32'd0);
      chk("reset valid", 32'(valid), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Directed vector table.
      for (int i = 0; i < 21; i++) begin
         cycle(tbl[i].dh, tbl[i].fl, tbl[i].br, tbl[i].ba, tbl[i].jp, tbl[i].ja, tbl[i].rdy, 1'b0);
         chk($sformatf("vec%0d pc", i), 32'(pc), 32'(tbl[i].e_pc));
         chk($sformatf("vec%0d pc_plus4", i), 32'(pp4), 32'(tbl[i].e_pp4));
         chk($sformatf("vec%0d instr", i), instr, tbl[i].e_instr);
         chk($sformatf("vec%0d valid", i), 32'(valid), 32'(tbl[i].e_valid));
      end

      // Reset mid-fetch, then first fetch from the reset PC.
      mid_reset("midfetch");
      cycle(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1, 1'b1);
      chk_first_fetch("after midfetch");

      // Reset during a stall: no held state survives.
      cycle(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1, 1'b1);
      mid_reset("midstall");
      cycle(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1, 1'b1);
      chk_first_fetch("after midstall");

      // Reset during a memory wait.
      cycle(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b1);
      mid_reset("midwait");
      cycle(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1, 1'b1);
      chk_first_fetch("after midwait");

      // Randomized traffic against the reference model.
      mem_key = $urandom;
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(99) >= 15, $urandom_range(99) < 10, $urandom_range(99) < 15,
               10'($urandom), $urandom_range(99) < 10, 10'($urandom),
               $urandom_range(99) >= 20, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/if_pipe_stage.md
Name: if_pipe_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the 10-bit PC and presents a fetch address to instruction memory.
- Selects the next PC from sequential, branch or jump targets; decode computes those targets and feeds them back.
- Drives the IF/ID pipeline register (if_id_pc_plus4, if_id_instr) that decode consumes, with stall, flush and memory-wait handling.

Parameters:
- PC_WIDTH, 10, byte-address width of PC, branch and jump targets.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 10'd0, PC value loaded on reset.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_addr  output  PC_WIDTH  fetch address; equals the current PC.
- imem_rdata  input  INSTR_WIDTH  instruction at imem_addr, valid in the same cycle when imem_ready=1.
- imem_ready  input  1  1 = imem_rdata valid this cycle.
- Data_Hazard  input  1  active-low stall: 0 = hold PC and IF/ID.
- IF_Flush  input  1  1 = replace IF/ID contents with a bubble.
- branch_taken  input  1  from decode: redirect to branch_address.
- branch_address  input  PC_WIDTH  branch target.
- jump  input  1  from decode: redirect to jump_address.
- jump_address  input  PC_WIDTH  jump target.
- pc  output  PC_WIDTH  current PC (debug/trace).
- if_id_pc_plus4  output  PC_WIDTH  registered PC+4 of the fetched instruction.
- if_id_instr  output  INSTR_WIDTH  registered instruction; 0 (NOP) for a bubble.
- if_id_valid  output  1  1 = if_id_instr is a real fetched instruction.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately): pc=RESET_PC, if_id_pc_plus4=0, if_id_instr=0, if_id_valid=0. Deassertion is sampled synchronously; the first fetch is from RESET_PC.
- Combinational: imem_addr=pc. pc_plus4=pc+4, truncated to PC_WIDTH, so 10'd1020 wraps to 0. Targets are used as given, with no alignment check.
- Per-edge priority, first match wins:
  1. Stall (Data_Hazard=0): pc and all IF/ID registers hold. Redirect, flush and imem_ready are ignored.
  2. Redirect (jump=1, or branch_taken=1): pc <= jump_address if jump=1, else branch_address (jump beats branch when both are high). IF/ID loads a bubble: instr=0, valid=0, pc_plus4=0. The wrong-path instruction is squashed regardless of IF_Flush.
  3. Flush (IF_Flush=1, no redirect): IF/ID loads a bubble; pc <= pc_plus4 if imem_ready=1, else pc holds.
  4. Memory wait (imem_ready=0): pc holds; IF/ID loads a bubble.
  5. Normal: pc <= pc_plus4; if_id_instr <= imem_rdata, if_id_pc_plus4 <= pc_plus4, if_id_valid <= 1.
- Latency: an instruction fetched at PC=p appears on if_id_instr one cycle later, with if_id_pc_plus4=p+4.
- Branch penalty: one bubble, since the redirect is sampled while the branch sits in IF/ID.
- Reset mid-operation, including mid-wait or mid-stall, overrides everything on the same cycle with no pending-state carryover.
- No other internal state exists; the block has no FSM beyond the PC and the IF/ID registers.

Decomposition:
- Shared package holds:
  - NOP_INSTR (32'd0)
  - PC_INC (4)
  - next-PC select encoding as a localparam enum {SEL_HOLD, SEL_SEQ, SEL_BRANCH, SEL_JUMP}.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with hold, bubble-load and async active-low reset. The PC register and next-PC select stay in the top.

Test Plan:
- Reset then 4 cycles, imem_ready=1, imem returns 32'h1000_0000+addr → imem_addr 0,4,8,12; if_id_instr lags one cycle with if_id_pc_plus4 4,8,12; if_id_valid=1 from the 2nd cycle.
- At pc=8, hold Data_Hazard=0 for 2 cycles while also pulsing branch_taken=1 (branch_address=10'd100) → pc stays 8 and IF/ID is unchanged for both cycles; fetch resumes at 8.
- At pc=12, branch_taken=1, branch_address=10'd100 → next pc=100; IF/ID bubble (instr=0, valid=0); next cycle if_id_pc_plus4=104.
- jump=1 (jump_address=10'd200) and branch_taken=1 (branch_address=10'd100) in the same cycle → pc=200, one bubble.
- imem_ready=0 for 3 cycles at pc=16 → pc holds 16, three bubbles; on ready=1, if_id_instr = word at 16.
- Set pc to 1020 via jump_address=10'd1020, then 2 normal cycles → pc wraps to 0 with if_id_pc_plus4=0. Then assert reset=0 between clock edges mid-fetch → outputs clear immediately, pc=0.
